// File: rtl/fuzz_pkg.sv
// Shared constants, FSM encoding and the xorshift32 step used by the
// stimulus generator and response compactor.
package fuzz_pkg;

    localparam logic [31:0] LANE_GOLDEN       = 32'h9E3779B9;
    localparam logic [31:0] MISR_POLY_DEFAULT = 32'h87;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fsm_state_e;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    // A zero seed would lock the lane at zero forever, so it is bumped to 1.
    function automatic logic [31:0] lane_seed(input logic [31:0] base, input int unsigned k);
        logic [31:0] s;
        s = base + k[31:0] * LANE_GOLDEN;
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

endpackage

// File: rtl/xorshift_lane.sv
// One 32-bit xorshift lane: reseeds to its fixed seed, otherwise steps on request.
module xorshift_lane
    import fuzz_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reseed,
    input  logic        step,
    output logic [31:0] lane
);

    logic [31:0] lane_q;
    logic [31:0] lane_d;

    always_comb begin
        lane_d = lane_q;
        if (reseed) begin
            lane_d = SEED;
        end else if (step) begin
            lane_d = xorshift32(lane_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= SEED;
        end else begin
            lane_q <= lane_d;
        end
    end

    assign lane = lane_q;

endmodule

// File: rtl/fuzz_stim_misr.sv
// Drives NUM_VEC pseudo-random vectors onto a DUT and folds its delayed
// response into a MISR signature for cross-tool comparison.
module fuzz_stim_misr
    import fuzz_pkg::*;
#(
    parameter int               IN_W       = 256,
    parameter int               OUT_W      = 192,
    parameter int               NUM_VEC    = 21,
    parameter int               HOLD       = 1,
    parameter int               LAT        = 0,
    parameter bit               ZERO_FIRST = 1'b1,
    parameter logic [31:0]      SEED       = 32'h1,
    parameter logic [OUT_W-1:0] MISR_POLY  = OUT_W'(MISR_POLY_DEFAULT)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [OUT_W-1:0]               resp,
    output logic [IN_W-1:0]                stim,
    output logic                           busy,
    output logic                           done,
    output logic                           sample,
    output logic [$clog2(NUM_VEC+1)-1:0]   vec_cnt,
    output logic [OUT_W-1:0]               signature
);

    localparam int L    = (IN_W + 31) / 32;
    localparam int LW   = L * 32;
    localparam int VC_W = $clog2(NUM_VEC + 1);
    localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int DC_W = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [VC_W-1:0] VC_LAST    = VC_W'(NUM_VEC);
    localparam logic [HC_W-1:0] HOLD_LAST  = HC_W'(HOLD - 1);
    localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'((LAT > 0) ? LAT - 1 : 0);

    fsm_state_e       state_q, state_d;
    logic [VC_W-1:0]  vc_q, vc_d;
    logic [HC_W-1:0]  hold_q, hold_d;
    logic [DC_W-1:0]  drain_q, drain_d;
    logic [OUT_W-1:0] sig_q, sig_d;

    logic             issue;
    logic             dly_pulse;
    logic             run_entry;
    logic             lane_step;
    logic [LW-1:0]    lane_bus;
    logic [OUT_W-1:0] fold_val;

    for (genvar k = 0; k < L; k++) begin : g_lane
        xorshift_lane #(
            .SEED(lane_seed(SEED, k))
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .reseed (run_entry),
            .step   (lane_step),
            .lane   (lane_bus[k*32 +: 32])
        );
    end

    // The issue pulse travels through LAT flops so the fold lines up with the DUT pipeline.
    if (LAT == 0) begin : g_no_dly
        assign dly_pulse = issue;
    end else begin : g_dly
        logic [LAT-1:0] sr_q, sr_d;

        always_comb begin
            sr_d = (sr_q << 1) | LAT'(issue);
            if (run_entry) begin
                sr_d = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sr_q <= '0;
            end else begin
                sr_q <= sr_d;
            end
        end

        assign dly_pulse = sr_q[LAT-1];
    end

    assign issue     = (state_q == RUN) && (hold_q == HOLD_LAST);
    assign run_entry = start && ((state_q == IDLE) || (state_q == DONE));
    assign fold_val  = {sig_q[OUT_W-2:0], 1'b0} ^ (sig_q[OUT_W-1] ? MISR_POLY : '0) ^ resp;

    always_comb begin
        state_d   = state_q;
        vc_d      = vc_q;
        hold_d    = hold_q;
        drain_d   = drain_q;
        sig_d     = sig_q;
        lane_step = 1'b0;

        if (dly_pulse) begin
            sig_d = fold_val;
        end

        case (state_q)
            IDLE, DONE: begin
                if (run_entry) begin
                    state_d = RUN;
                    vc_d    = VC_W'(1);
                    hold_d  = '0;
                    drain_d = '0;
                    sig_d   = '0;
                end
            end
            RUN: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (vc_q == VC_LAST) begin
                        drain_d = '0;
                        if (LAT > 0) begin
                            state_d = DRAIN;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        vc_d      = vc_q + 1'b1;
                        lane_step = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vc_q    <= '0;
            hold_q  <= '0;
            drain_q <= '0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            vc_q    <= vc_d;
            hold_q  <= hold_d;
            drain_q <= drain_d;
            sig_q   <= sig_d;
        end
    end

    always_comb begin
        stim = '0;
        if ((state_q == RUN) && !(ZERO_FIRST && (vc_q == VC_W'(1)))) begin
            stim = lane_bus[IN_W-1:0];
        end
    end

    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign sample    = dly_pulse;
    assign vec_cnt   = vc_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_fuzz_stim_misr.sv
// Bench for fuzz_stim_misr: three configurations run side by side against a
// vector/signature model built from the generator and MISR rules.
module tb_fuzz_stim_misr;

    localparam int               IN_W  = 96;
    localparam int               OUT_W = 64;
    localparam logic [31:0]      SEED  = 32'h1;
    localparam logic [OUT_W-1:0] POLY  = 64'h87;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT wiring ----------------
    logic [IN_W-1:0]  stim0, stim1, stim2;
    logic [OUT_W-1:0] resp0, resp1, resp2;
    logic [OUT_W-1:0] sig0, sig1, sig2;
    logic [OUT_W-1:0] noise_cur = '0;
    logic [OUT_W-1:0] p1 = '0, p2 = '0, p3 = '0;
    logic             busy0, busy1, busy2, done0, done1, done2, samp0, samp1, samp2;
    logic [2:0]       vc0, vc1, vc2;

    assign resp0 = stim0[OUT_W-1:0] ^ noise_cur;
    assign resp2 = '0;
    // Three-register loopback standing in for a pipelined DUT.
    always @(posedge clk) begin
        p1 <= stim1[OUT_W-1:0];
        p2 <= p1;
        p3 <= p2;
    end
    assign resp1 = p3;

    fuzz_stim_misr #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(4), .HOLD(1), .LAT(0),
                     .ZERO_FIRST(1'b1), .SEED(SEED), .MISR_POLY(POLY)) dut0 (
        .clk(clk), .rst(rst), .start(start), .resp(resp0), .stim(stim0), .busy(busy0),
        .done(done0), .sample(samp0), .vec_cnt(vc0), .signature(sig0));

    fuzz_stim_misr #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(4), .HOLD(1), .LAT(3),
                     .ZERO_FIRST(1'b1), .SEED(SEED), .MISR_POLY(POLY)) dut1 (
        .clk(clk), .rst(rst), .start(start), .resp(resp1), .stim(stim1), .busy(busy1),
        .done(done1), .sample(samp1), .vec_cnt(vc1), .signature(sig1));

    fuzz_stim_misr #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(5), .HOLD(2), .LAT(0),
                     .ZERO_FIRST(1'b1), .SEED(SEED), .MISR_POLY(POLY)) dut2 (
        .clk(clk), .rst(rst), .start(start), .resp(resp2), .stim(stim2), .busy(busy2),
        .done(done2), .sample(samp2), .vec_cnt(vc2), .signature(sig2));

    // ---------------- reference model ----------------
    int               cfg_h[3]   = '{1, 1, 2};
    int               cfg_n[3]   = '{4, 4, 5};
    int               cfg_lat[3] = '{0, 3, 0};
    logic [IN_W-1:0]  vec[0:7];
    logic [OUT_W-1:0] noise[0:7];
    logic [OUT_W-1:0] msig[3];
    int               nsamp[3];
    logic [OUT_W-1:0] base_sig;
    int               n_err = 0;
    int               n_chk = 0;

    function automatic logic [31:0] xs(input logic [31:0] x);
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x;
    endfunction

    task automatic build_vectors();
        logic [31:0] lane[3];
        for (int k = 0; k < 3; k++) begin
            lane[k] = SEED + k * 32'h9E3779B9;
            if (lane[k] == 0) lane[k] = 1;
        end
        vec[0] = '0;
        for (int i = 1; i < 8; i++) begin
            for (int k = 0; k < 3; k++) lane[k] = xs(lane[k]);
            vec[i] = {lane[2], lane[1], lane[0]};
        end
    endtask

    function automatic logic [OUT_W-1:0] model_resp(input int d, input int i);
        if (d == 0) return vec[i][OUT_W-1:0] ^ noise[i];
        if (d == 1) return vec[i][OUT_W-1:0];
        return '0;
    endfunction

    function automatic logic [OUT_W-1:0] misr(input logic [OUT_W-1:0] s, input logic [OUT_W-1:0] r);
        return (s << 1) ^ (s[OUT_W-1] ? POLY : '0) ^ r;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [IN_W-1:0] obs, input logic [IN_W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input int d, input logic [IN_W-1:0] st, input logic b, input logic dn,
                               input logic sm, input logic [2:0] vc, input logic [OUT_W-1:0] sg);
        chk($sformatf("d%0d_rst_stim", d), st, '0);
        chk($sformatf("d%0d_rst_ctl", d), {b, dn, sm, vc}, '0);
        chk($sformatf("d%0d_rst_sig", d), sg, '0);
    endtask

    // Checks one post-edge cycle j of a run started at edge t, then advances the model.
    task automatic check_cycle(input int d, input int j, input logic [IN_W-1:0] st, input logic b,
                               input logic dn, input logic sm, input logic [2:0] vc,
                               input logic [OUT_W-1:0] sg);
        int nh;
        int f;
        logic e_busy;
        logic e_samp;
        nh     = cfg_n[d] * cfg_h[d];
        f      = j + 1 - cfg_lat[d];
        e_busy = (j < nh + cfg_lat[d]);
        e_samp = (f > 0) && (f % cfg_h[d] == 0) && (f / cfg_h[d] <= cfg_n[d]);
        chk($sformatf("d%0d_c%0d_stim", d, j), st, (j < nh) ? vec[j / cfg_h[d]] : '0);
        chk($sformatf("d%0d_c%0d_busy", d, j), b, e_busy);
        chk($sformatf("d%0d_c%0d_done", d, j), dn, !e_busy);
        chk($sformatf("d%0d_c%0d_vcnt", d, j), vc, (j < nh) ? j / cfg_h[d] + 1 : cfg_n[d]);
        chk($sformatf("d%0d_c%0d_samp", d, j), sm, e_samp);
        chk($sformatf("d%0d_c%0d_sig", d, j), sg, msig[d]);
        if (sm) nsamp[d]++;
        if (e_samp) msig[d] = misr(msig[d], model_resp(d, f / cfg_h[d] - 1));
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_run(input bit poke_start);
        for (int d = 0; d < 3; d++) begin
            msig[d]  = '0;
            nsamp[d] = 0;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 12; j++) begin
            noise_cur = (j < 4) ? noise[j] : '0;
            check_cycle(0, j, stim0, busy0, done0, samp0, vc0, sig0);
            check_cycle(1, j, stim1, busy1, done1, samp1, vc1, sig1);
            check_cycle(2, j, stim2, busy2, done2, samp2, vc2, sig2);
            if (poke_start && j >= 1 && j <= 3) start = (j == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            start = 1'b0;
        end
        noise_cur = '0;
        chk("d0_fold_count", nsamp[0], cfg_n[0]);
        chk("d1_fold_count", nsamp[1], cfg_n[1]);
        chk("d2_fold_count", nsamp[2], cfg_n[2]);
    endtask

    task automatic clear_noise();
        for (int i = 0; i < 8; i++) noise[i] = '0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        build_vectors();
        clear_noise();
        rst = 1'b1;
        tick();
        tick();
        check_reset(0, stim0, busy0, done0, samp0, vc0, sig0);
        check_reset(1, stim1, busy1, done1, samp1, vc1, sig1);
        check_reset(2, stim2, busy2, done2, samp2, vc2, sig2);
        rst = 1'b0;
        tick();

        // Baseline loopback run, with stray start pulses while busy.
        do_run(1'b1);
        base_sig = msig[0];
        chk("d1_sig_vs_lat0", sig1, base_sig);
        chk("d2_sig_zero", sig2, '0);

        // Random response perturbation, restarted from DONE.
        for (int i = 0; i < 4; i++) noise[i] = {$urandom, $urandom};
        do_run(1'b0);

        // Single-bit flip on vector 3 only.
        clear_noise();
        noise[3] = 64'h1;
        do_run(1'b0);
        n_chk++;
        assert ((sig0 ^ base_sig) !== '0) else begin
            n_err++;
            $error("FAIL d0_flip_detect observed=%0h expected=not %0h", sig0, base_sig);
        end

        // Reset mid-run at vector 2, with start asserted on the same edge.
        clear_noise();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check_reset(0, stim0, busy0, done0, samp0, vc0, sig0);
        check_reset(1, stim1, busy1, done1, samp1, vc1, sig1);
        check_reset(2, stim2, busy2, done2, samp2, vc2, sig2);
        tick();
        do_run(1'b0);
        chk("d0_sig_after_rst", sig0, base_sig);
        chk("d1_sig_after_rst", sig1, base_sig);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
